// File: rtl/mod_exp_engine_if.sv
// Request/response bundle for the modular exponentiation engine.
// Master issues start with operands; slave returns result, busy, completion pulse and error.
interface mod_exp_engine_if #(
   parameter int WIDTH_N     = 8,
   parameter int WIDTH_DEG   = 8,
   parameter int WIDTH_MSG_I = 8
);
   logic                   start;
   logic [WIDTH_MSG_I-1:0] in;
   logic [WIDTH_DEG-1:0]   degree;
   logic [WIDTH_N-1:0]     n;
   logic [WIDTH_N-1:0]     out;
   logic                   busy;
   logic                   down;
   logic                   err;

   modport master (
      output start, in, degree, n,
      input  out, busy, down, err
   );

   modport slave (
      input  start, in, degree, n,
      output out, busy, down, err
   );
endinterface

// File: rtl/mod_exp_engine.sv
// Constant-time square-and-multiply in^degree mod n; down at T+2*WIDTH_DEG+2 (T+3 if n<2).
// No backpressure: start is taken only in IDLE, starts while busy are dropped.
module mod_exp_engine #(
   parameter int WIDTH_N     = 8,
   parameter int WIDTH_DEG   = 8,
   parameter int WIDTH_MSG_I = 8
) (
   input logic              clk,
   input logic              rst,
   mod_exp_engine_if.slave  bus
);
   localparam int PW    = 2 * WIDTH_N;
   localparam int IDX_W = (WIDTH_DEG > 1) ? $clog2(WIDTH_DEG) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH_MSG_I-1:0] in_q, in_d;
   logic [WIDTH_DEG-1:0]   deg_q, deg_d;
   logic [WIDTH_N-1:0]     n_q, n_d;
   logic [WIDTH_N-1:0]     base_q, base_d;
   logic [WIDTH_N-1:0]     acc_q, acc_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   errp_q, errp_d;
   logic [WIDTH_N-1:0]     out_q, out_d;
   logic                   busy_q, busy_d;
   logic                   down_q, down_d;
   logic                   err_q, err_d;

   logic [WIDTH_N-1:0]     mod_n;
   logic [PW-1:0]          sqr_full, mul_full;
   logic [WIDTH_N-1:0]     sqr_red, mul_red, in_red;
   logic                   n_invalid;

   // Divisor is forced nonzero so the reducers never see n=0; that case is trapped in LOAD anyway.
   assign mod_n     = (n_q == '0) ? WIDTH_N'(1) : n_q;
   assign n_invalid = ((n_q >> 1) == '0);

   // Full double-width products; the multiply runs every MUL cycle whether or not its result is kept.
   assign sqr_full = PW'(acc_q) * PW'(acc_q);
   assign mul_full = PW'(acc_q) * PW'(base_q);
   assign sqr_red  = WIDTH_N'(sqr_full % PW'(mod_n));
   assign mul_red  = WIDTH_N'(mul_full % PW'(mod_n));
   assign in_red   = WIDTH_N'(WIDTH_N'(in_q) % mod_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         in_q    <= '0;
         deg_q   <= '0;
         n_q     <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         errp_q  <= 1'b0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         down_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         in_q    <= in_d;
         deg_q   <= deg_d;
         n_q     <= n_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         errp_q  <= errp_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         down_q  <= down_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      in_d    = in_q;
      deg_d   = deg_q;
      n_d     = n_q;
      base_d  = base_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      errp_d  = errp_q;
      out_d   = out_q;
      busy_d  = busy_q;
      down_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               in_d    = bus.in;
               deg_d   = bus.degree;
               n_d     = bus.n;
               errp_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Invalid modulus spends a second LOAD cycle so its pulse lands at T+3.
            if (n_invalid) begin
               if (errp_q) state_d = DONE;
               else        errp_d  = 1'b1;
            end else begin
               base_d  = in_red;
               acc_d   = WIDTH_N'(1);
               idx_d   = IDX_W'(WIDTH_DEG - 1);
               state_d = SQR;
            end
         end
         SQR: begin
            acc_d   = sqr_red;
            state_d = MUL;
         end
         MUL: begin
            if (deg_q[idx_q]) acc_d = mul_red;
            if (idx_q == '0) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = SQR;
            end
         end
         DONE: begin
            out_d   = errp_q ? '0 : acc_q;
            err_d   = errp_q;
            down_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.down = down_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboarded random and directed bench for mod_exp_engine against a plain-arithmetic power model.
module tb_mod_exp_engine;
   localparam int WN      = 8;
   localparam int WD      = 8;
   localparam int WM      = 8;
   localparam int LAT_OK  = 2 * WD + 2;
   localparam int LAT_ERR = 3;

   typedef struct {
      int unsigned exp_out;
      bit          exp_err;
      int          t0;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   bit   prev_down = 1'b0;
   exp_t sb[$];

   mod_exp_engine_if #(.WIDTH_N(WN), .WIDTH_DEG(WD), .WIDTH_MSG_I(WM)) bif ();

   mod_exp_engine #(.WIDTH_N(WN), .WIDTH_DEG(WD), .WIDTH_MSG_I(WM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: repeated multiplication, result 0 for an invalid modulus.
   function automatic int unsigned ref_modexp(input int unsigned b, input int unsigned e,
                                              input int unsigned m);
      longint unsigned r = 1;
      if (m < 2) return 0;
      for (int unsigned i = 0; i < e; i++) r = (r * b) % m;
      return int'(r % m);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int unsigned a, input int unsigned d, input int unsigned m);
      exp_t e;
      bif.in     = WM'(a);
      bif.degree = WD'(d);
      bif.n      = WN'(m);
      bif.start  = 1'b1;
      e.exp_out  = ref_modexp(a, d, m);
      e.exp_err  = (m < 2);
      e.t0       = cyc + 1;
      e.lat      = (m < 2) ? LAT_ERR : LAT_OK;
      sb.push_back(e);
      @(posedge clk); #1;
      bif.start  = 1'b0;
      bif.in     = WM'($urandom);
      bif.degree = WD'($urandom);
      bif.n      = WN'($urandom);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (bif.busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("idle_timeout", 64'(bif.busy), 64'd0);
   endtask

   task automatic wait_down();
      int k = 0;
      while (!bif.down && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("down_timeout", 64'(bif.down), 64'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out"},  64'(bif.out),  64'd0);
      check({tag, "_busy"}, 64'(bif.busy), 64'd0);
      check({tag, "_down"}, 64'(bif.down), 64'd0);
      check({tag, "_err"},  64'(bif.err),  64'd0);
   endtask

   // Monitor: pops the scoreboard on every completion pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_down) begin
            check("down_width", 64'(bif.down), 64'd0);
            check("err_clear",  64'(bif.err),  64'd0);
         end
         prev_down = bif.down;
         if (bif.down) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL spurious_down: got down=1 required no pulse (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("result",  64'(bif.out),  64'(e.exp_out));
               check("err",     64'(bif.err),  64'(e.exp_err));
               check("latency", 64'(cyc - e.t0), 64'(e.lat));
               check("busy_at_down", 64'(bif.busy), 64'd0);
            end
         end else if (sb.size() > 0 && cyc >= sb[0].t0) begin
            check("busy", 64'(bif.busy), 64'd1);
         end
      end else begin
         prev_down = 1'b0;
      end
   end

   initial begin
      bif.start  = 1'b0;
      bif.in     = '0;
      bif.degree = '0;
      bif.n      = '0;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      issue(5, 3, 13);      wait_idle();
      issue(20, 1, 13);     wait_down();
      issue(7, 0, 11);      wait_idle();
      issue(2, 8, 251);     wait_idle();
      issue(255, 255, 255); wait_idle();
      issue(9, 4, 1);       wait_idle();
      issue(9, 4, 0);       wait_idle();

      // Start while busy must be dropped.
      issue(5, 3, 13);
      repeat (4) begin @(posedge clk); #1; end
      bif.start  = 1'b1;
      bif.in     = 99;
      bif.degree = 77;
      bif.n      = 200;
      @(posedge clk); #1;
      bif.start  = 1'b0;
      wait_idle();
      repeat (3) begin @(posedge clk); #1; end

      // Reset lands on edge T+9 of a running operation.
      issue(123, 200, 97);
      repeat (8) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      check_zero("abort");
      rst = 1'b0;
      repeat (25) begin @(posedge clk); #1; end
      issue(123, 200, 97);  wait_idle();

      for (int i = 0; i < 40; i++) begin
         int unsigned a, d, m;
         a = $urandom_range(0, 255);
         d = $urandom_range(0, 255);
         m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         issue(a, d, m);
         if ($urandom_range(0, 3) == 0) begin
            wait_down();
         end else begin
            wait_idle();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
      end

      wait_idle();
      repeat (3) begin @(posedge clk); #1; end
      check("sb_drain", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 Parameter WIDTH_N, default 8: width of modulus and result.
REQ-002 Parameter WIDTH_DEG, default 8: width of exponent.
REQ-003 Parameter WIDTH_MSG_I, default 8: width of input message; SHALL be 1..WIDTH_N.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 in  in  WIDTH_MSG_I  message (base).
REQ-008 degree  in  WIDTH_DEG  exponent e.
REQ-009 n  in  WIDTH_N  modulus.
REQ-010 out  out  WIDTH_N  result in^degree mod n, registered.
REQ-011 busy  out  1  high while an operation is in progress, registered.
REQ-012 down  out  1  one-cycle completion pulse, registered.
REQ-013 err  out  1  invalid-modulus flag, valid while down=1, registered.

Function
REQ-014 States SHALL be IDLE, LOAD, SQR, MUL, DONE; one state transition per clock edge.
REQ-015 IDLE: on start=1 at edge T, latch in, degree and n into internal registers, set busy=1, go to LOAD; otherwise stay in IDLE.
REQ-016 Input changes after edge T SHALL NOT affect the running operation.
REQ-017 start while busy=1 SHALL be ignored, with no queueing.
REQ-018 LOAD: if latched n<2, go to DONE with err pending; else base<=in mod n, acc<=1, bit index<=WIDTH_DEG-1, go to SQR.
REQ-019 SQR: acc<=(acc*acc) mod n; go to MUL.
REQ-020 MUL: if degree[index]=1 then acc<=(acc*base) mod n, else acc unchanged; the multiply SHALL be computed every time (constant-time).
REQ-021 MUL exit: if index=0 go to DONE, else index<=index-1 and go to SQR.
REQ-022 Exponent bits SHALL be scanned MSB to LSB, covering all WIDTH_DEG bits regardless of leading zeros.
REQ-023 Products SHALL be held at 2*WIDTH_N bits with no truncation before reduction; reduction SHALL complete within the same cycle.
REQ-024 DONE: out<=acc (or 0 if err), err<=invalid flag, down<=1, busy<=0, go to IDLE.
REQ-025 down SHALL be high for exactly one cycle; err SHALL clear when down falls.
REQ-026 out SHALL hold its value until the next DONE or reset.
REQ-027 Valid-n latency: down rises at edge T+2*WIDTH_DEG+2, independent of operand values.
REQ-028 Invalid-n latency: down rises at edge T+3.
REQ-029 degree=0 SHALL give out=1 for n>=2.
REQ-030 in>=n SHALL be handled by the LOAD reduction.
REQ-031 A new start SHALL be accepted on the cycle down is high (state is IDLE), allowing back-to-back operations.

Reset
REQ-032 rst=1 at an edge SHALL force state=IDLE and out=0, busy=0, down=0, err=0, and clear all internal registers.
REQ-033 Reset SHALL take priority over start and SHALL abort any operation in progress, with no down pulse for it.

Verification (WIDTH_N=8, WIDTH_DEG=8, WIDTH_MSG_I=8)
REQ-034 in=5, degree=3, n=13, start pulse -> out=8, err=0, down one cycle at T+18, busy high T..T+17.
REQ-035 in=20, degree=1, n=13 -> out=7; then in=7, degree=0, n=11, started on the down cycle -> out=1 at +18.
REQ-036 in=2, degree=8, n=251 -> out=5; in=255, degree=255, n=255 -> out=0; latency 18 in both cases.
REQ-037 n=1 and n=0 -> down at T+3, err=1, out=0; err=0 on the following cycle.
REQ-038 Start while busy with different operands -> ignored; the first result is unchanged and exactly one down pulse occurs.
REQ-039 rst asserted at T+9 mid-operation -> all outputs 0 next cycle, no down pulse; a fresh start after reset gives the correct result.
